pc_ras: RTL and testbench
=========================

Name: pc_ras

Overview:
- Next-generation program counter for the word-addressed CPU.
- Adds over the previous PC:
  - width generalisation;
  - explicit priority between redirect sources, with multi-select error detection;
  - jump-and-link and return, backed by a parametrised return-address stack (RAS) with overflow/underflow handling.
- Sits between decode/branch-compare and instruction memory. `pc_addr` feeds fetch; `link_addr` feeds register-file writeback.

Parameters:
- BITS, 32, word width of the PC and all address operands (>= 8)
- RAS_DEPTH, 4, number of RAS entries; power of 2, >= 2
- RESET_ADDR, 0, value loaded into `pc_addr` on reset

Ports:
- clk  input  1  system clock
- rst_  input  1  synchronous active-low reset, sampled on posedge clk
- load_instr  input  1  advance the PC this cycle; when low, all state holds
- addr  input  BITS-6  jump target field
- jmp  input  1  absolute jump
- jal  input  1  absolute jump and link (push return address)
- jreg  input  1  jump to r1_data
- ret  input  1  return: pop RAS
- breq  input  1  branch-on-equal request
- equal  input  1  compare result, equal
- brne  input  1  branch-on-not-equal request
- not_equal  input  1  compare result, not equal
- sign_ext_imm  input  BITS  branch offset, in words
- r1_data  input  BITS  register value, used for jreg and for the ret fallback
- pc_addr  output  BITS  current instruction address
- link_addr  output  BITS  pc_addr+1, combinational
- redirect  output  1  combinational; a non-sequential target is selected and load_instr=1
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_ovf  output  1  sticky; a push occurred while the RAS was full
- ras_unf  output  1  sticky; a pop occurred while the RAS was empty
- multi_sel  output  1  combinational; more than one source is active
- redirect_cnt  output  16  taken-redirect counter (see Optional Feature)

Behaviour:
- Reset (clk edge with rst_=0):
  - pc_addr=RESET_ADDR;
  - RAS pointer and ras_count=0;
  - ras_ovf=0, ras_unf=0, redirect_cnt=0;
  - RAS entry contents are don't-care.
  - Reset overrides load_instr and all other inputs in the same cycle.
- Active sources:
  - ret, jreg, jal, jmp as driven;
  - breq only when breq&&equal;
  - brne only when brne&&not_equal.
- Priority (highest first): ret > jreg > jal > jmp > breq > brne > sequential.
- Exactly one target is chosen; no OR-combining of targets.
- multi_sel=1 when two or more sources are active. It is informational only and does not alter the priority choice.
- Targets:
  - sequential = pc_addr+1;
  - branch = pc_addr+sign_ext_imm, modulo 2^BITS;
  - jmp/jal = {pc_addr[BITS-1:BITS-4], 2'b00, addr};
  - jreg = r1_data;
  - ret = RAS top when ras_count>0, else r1_data.
- All address arithmetic is modulo 2^BITS: all-ones+1 wraps to 0.
- Update: at posedge clk with rst_=1 and load_instr=1, pc_addr <= selected target (1-cycle latency). With load_instr=0, PC and RAS hold.
- RAS push: happens only when jal is the winning source and load_instr=1.
  - Pushes link_addr (pc_addr+1 of the jal instruction).
  - Storage is a circular buffer.
  - When full: the oldest entry is overwritten, ras_count stays at RAS_DEPTH, ras_ovf is set.
- RAS pop: happens only when ret is the winning source and load_instr=1.
  - ras_count decrements.
  - When empty: no pointer change, r1_data is used as the target, ras_unf is set.
- jal+ret together: ret wins, no push, net pop.
- Push and pop never occur in the same cycle.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- Defined: redirect_cnt increments on every clock with redirect=1.
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Holds while load_instr=0.
- Undefined: redirect_cnt is tied to 0 and no counter flops are instantiated. The port always exists.

Decomposition:
- Shared package pc_pkg:
  - enum pc_src_t {SRC_SEQ, SRC_BRNE, SRC_BREQ, SRC_JMP, SRC_JAL, SRC_JREG, SRC_RET};
  - localparam PC_JFIELD_PAD=2.
- Sub-module ras_stack (parameters BITS, RAS_DEPTH):
  - ports: push, pop, push_data, top, count, ovf, unf;
  - contains the circular buffer and the sticky flags.
- The top level holds source priority encoding, target mux, PC register and optional counter.

Test Plan:
- rst_=0 for 2 clocks, then load_instr=1 with no sources -> pc_addr 0,1,2,3 on successive clocks; ras_count=0; flags 0.
- pc_addr=0x10, breq=1, equal=1, sign_ext_imm=0xFFFFFFFC -> pc_addr=0x0C. With equal=0 instead -> 0x11. With load_instr=0 -> stays 0x10.
- jal at pc 0x20 with addr=0x100, then ret at 0x100 -> pc 0x100, then 0x21; ras_count goes 1 then 0.
- RAS_DEPTH=4: five jal pushes (return addresses A1..A5) -> ras_ovf=1, count=4. Four rets return A5, A4, A3, A2. A fifth ret with r1_data=0x55 -> pc=0x55, ras_unf=1.
- jmp=1, jreg=1, ret=1 together with an empty RAS, r1_data=0x40 -> multi_sel=1; ret wins; pc=0x40; ras_unf=1.
- Sync reset asserted mid-sequence with load_instr=1 and jal=1 -> next pc=RESET_ADDR, count=0, no push. With PC_REDIRECT_CNT_EN defined, redirect_cnt=0 after reset, then 3 taken redirects -> 3.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program counter and its return-address stack.
// Source encoding is ordered lowest to highest priority.
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BRNE,
      SRC_BREQ,
      SRC_JMP,
      SRC_JAL,
      SRC_JREG,
      SRC_RET
   } pc_src_t;

   localparam int PC_JFIELD_PAD = 2;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with sticky overflow/underflow flags.
// A full push overwrites the oldest entry; an empty pop leaves state intact.
module ras_stack
   import pc_pkg::*;
#(
   parameter int BITS      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         push,
   input  logic                         pop,
   input  logic [BITS-1:0]              push_data,
   output logic [BITS-1:0]              top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         ovf,
   output logic                         unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [BITS-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   top_idx;
   logic            full;
   logic            empty;

   // ptr addresses the next free slot; the top sits one below it
   assign top_idx = ptr - PW'(1);
   assign top     = mem[top_idx];
   assign full    = (count == CW'(RAS_DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (!rst_) begin
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (full) begin
            ovf <= 1'b1;
         end else begin
            count <= count + CW'(1);
         end
      end else if (pop) begin
         if (empty) begin
            unf <= 1'b1;
         end else begin
            ptr   <= top_idx;
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

endmodule

// File: rtl/pc_ras.sv
// Program counter with prioritised redirects and a return-address stack.
// Optional taken-redirect counter enabled by PC_REDIRECT_CNT_EN.
module pc_ras
   import pc_pkg::*;
#(
   parameter int          BITS       = 32,
   parameter int          RAS_DEPTH  = 4,
   parameter logic [BITS-1:0] RESET_ADDR = '0
) (
   input  logic                        clk,
   input  logic                        rst_,
   input  logic                        load_instr,
   input  logic [BITS-7:0]             addr,
   input  logic                        jmp,
   input  logic                        jal,
   input  logic                        jreg,
   input  logic                        ret,
   input  logic                        breq,
   input  logic                        equal,
   input  logic                        brne,
   input  logic                        not_equal,
   input  logic [BITS-1:0]             sign_ext_imm,
   input  logic [BITS-1:0]             r1_data,
   output logic [BITS-1:0]             pc_addr,
   output logic [BITS-1:0]             link_addr,
   output logic                        redirect,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_ovf,
   output logic                        ras_unf,
   output logic                        multi_sel,
   output logic [15:0]                 redirect_cnt
);

   logic            act_breq;
   logic            act_brne;
   pc_src_t         src;
   logic [BITS-1:0] target;
   logic [BITS-1:0] ras_top;
   logic            push;
   logic            pop;

   assign act_breq  = breq & equal;
   assign act_brne  = brne & not_equal;
   assign multi_sel = $countones({ret, jreg, jal, jmp,
                                  act_breq, act_brne}) > 1;

   // strict priority: exactly one source wins
   always_comb begin
      src = SRC_SEQ;
      if (ret)           src = SRC_RET;
      else if (jreg)     src = SRC_JREG;
      else if (jal)      src = SRC_JAL;
      else if (jmp)      src = SRC_JMP;
      else if (act_breq) src = SRC_BREQ;
      else if (act_brne) src = SRC_BRNE;
   end

   assign link_addr = pc_addr + BITS'(1);

   always_comb begin
      target = link_addr;
      unique case (src)
         SRC_RET:  target = (ras_count != '0) ? ras_top : r1_data;
         SRC_JREG: target = r1_data;
         SRC_JAL,
         SRC_JMP:  target = {pc_addr[BITS-1:BITS-4],
                             {PC_JFIELD_PAD{1'b0}}, addr};
         SRC_BREQ,
         SRC_BRNE: target = pc_addr + sign_ext_imm;
         default:  target = link_addr;
      endcase
   end

   assign redirect = load_instr && (src != SRC_SEQ);
   assign push     = load_instr && (src == SRC_JAL);
   assign pop      = load_instr && (src == SRC_RET);

   always_ff @(posedge clk) begin
      if (!rst_) begin
         pc_addr <= RESET_ADDR;
      end else if (load_instr) begin
         pc_addr <= target;
      end
   end

   ras_stack #(
      .BITS      (BITS),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_      (rst_),
      .push      (push),
      .pop       (pop),
      .push_data (link_addr),
      .top       (ras_top),
      .count     (ras_count),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );

`ifdef PC_REDIRECT_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         cnt_q <= '0;
      end else if (redirect && cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign redirect_cnt = cnt_q;
`else
   assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ras.sv
// Scoreboard bench for pc_ras: stimulus queues expectations per clock,
// a negedge monitor pops and compares registered and snapshotted outputs.
module tb_pc_ras;

   logic        clk = 1'b0;
   logic        rst_;
   logic        load_instr;
   logic [25:0] addr;
   logic        jmp, jal, jreg, ret;
   logic        breq, equal, brne, not_equal;
   logic [31:0] sign_ext_imm;
   logic [31:0] r1_data;
   logic [31:0] pc_addr;
   logic [31:0] link_addr;
   logic        redirect;
   logic [2:0]  ras_count;
   logic        ras_ovf, ras_unf, multi_sel;
   logic [15:0] redirect_cnt;

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
      logic        ms;
      logic        rd;
      logic [15:0] rc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_rc = '0;
   logic        s_ms, s_rd;

   always #5 clk = ~clk;

   pc_ras dut (
      .clk          (clk),
      .rst_         (rst_),
      .load_instr   (load_instr),
      .addr         (addr),
      .jmp          (jmp),
      .jal          (jal),
      .jreg         (jreg),
      .ret          (ret),
      .breq         (breq),
      .equal        (equal),
      .brne         (brne),
      .not_equal    (not_equal),
      .sign_ext_imm (sign_ext_imm),
      .r1_data      (r1_data),
      .pc_addr      (pc_addr),
      .link_addr    (link_addr),
      .redirect     (redirect),
      .ras_count    (ras_count),
      .ras_ovf      (ras_ovf),
      .ras_unf      (ras_unf),
      .multi_sel    (multi_sel),
      .redirect_cnt (redirect_cnt)
   );

   // combinational outputs as seen just before the edge
   always @(posedge clk) begin
      s_ms <= multi_sel;
      s_rd <= redirect;
   end

   task automatic chk(string nm, string f, logic [31:0] act,
                      logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %h want %h", nm, f, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "pc", pc_addr, e.pc);
         chk(e.nm, "link", link_addr, e.pc + 32'd1);
         chk(e.nm, "count", 32'(ras_count), 32'(e.cnt));
         chk(e.nm, "ovf", 32'(ras_ovf), 32'(e.ovf));
         chk(e.nm, "unf", 32'(ras_unf), 32'(e.unf));
         chk(e.nm, "multi", 32'(s_ms), 32'(e.ms));
         chk(e.nm, "redir", 32'(s_rd), 32'(e.rd));
         chk(e.nm, "rcnt", 32'(redirect_cnt), 32'(e.rc));
      end
   end

   task automatic clr();
      jmp = 0; jal = 0; jreg = 0; ret = 0;
      breq = 0; equal = 0; brne = 0; not_equal = 0;
      addr = '0; sign_ext_imm = '0; r1_data = '0;
      load_instr = 1; rst_ = 1;
   endtask

   task automatic step(string nm, logic [31:0] pc, int cnt,
                       bit ovf, bit unf, bit ms, bit rd);
      exp_t e;
      @(posedge clk);
`ifdef PC_REDIRECT_CNT_EN
      if (!rst_) exp_rc = '0;
      else if (rd && exp_rc != 16'hFFFF) exp_rc = exp_rc + 16'd1;
`endif
      e.nm = nm; e.pc = pc; e.cnt = 3'(cnt);
      e.ovf = ovf; e.unf = unf; e.ms = ms; e.rd = rd;
      e.rc = exp_rc;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_jmp(string nm, logic [25:0] a, logic [31:0] pc,
                         int cnt, bit ovf, bit unf);
      clr(); jmp = 1; addr = a;
      step(nm, pc, cnt, ovf, unf, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      clr(); rst_ = 0; load_instr = 0;
      step("rst0", 32'h0, 0, 0, 0, 0, 0);
      step("rst1", 32'h0, 0, 0, 0, 0, 0);
      clr();
      step("seq1", 32'h1, 0, 0, 0, 0, 0);
      step("seq2", 32'h2, 0, 0, 0, 0, 0);
      step("seq3", 32'h3, 0, 0, 0, 0, 0);

      do_jmp("jmp10", 26'h10, 32'h10, 0, 0, 0);
      clr(); breq = 1; equal = 1; sign_ext_imm = 32'hFFFF_FFFC;
      step("breq_t", 32'h0C, 0, 0, 0, 0, 1);
      do_jmp("jmp10b", 26'h10, 32'h10, 0, 0, 0);
      clr(); breq = 1; not_equal = 1; sign_ext_imm = 32'hFFFF_FFFC;
      step("breq_nt", 32'h11, 0, 0, 0, 0, 0);
      do_jmp("jmp10c", 26'h10, 32'h10, 0, 0, 0);
      clr(); load_instr = 0; breq = 1; equal = 1;
      sign_ext_imm = 32'hFFFF_FFFC;
      step("hold", 32'h10, 0, 0, 0, 0, 0);
      clr(); brne = 1; not_equal = 1; breq = 1; equal = 1;
      sign_ext_imm = 32'h5;
      step("br_both", 32'h15, 0, 0, 0, 1, 1);
      clr(); brne = 1; not_equal = 1; sign_ext_imm = 32'h3;
      step("brne_t", 32'h18, 0, 0, 0, 0, 1);

      do_jmp("jmp20", 26'h20, 32'h20, 0, 0, 0);
      clr(); jal = 1; addr = 26'h100;
      step("jal100", 32'h100, 1, 0, 0, 0, 1);
      clr(); ret = 1;
      step("ret21", 32'h21, 0, 0, 0, 0, 1);

      clr(); jal = 1; addr = 26'h200;
      step("push1", 32'h200, 1, 0, 0, 0, 1);
      clr(); jal = 1; addr = 26'h300;
      step("push2", 32'h300, 2, 0, 0, 0, 1);
      clr(); jal = 1; addr = 26'h400;
      step("push3", 32'h400, 3, 0, 0, 0, 1);
      clr(); jal = 1; addr = 26'h500;
      step("push4", 32'h500, 4, 0, 0, 0, 1);
      clr(); jal = 1; addr = 26'h600;
      step("push5", 32'h600, 4, 1, 0, 0, 1);
      clr(); ret = 1;
      step("pop5", 32'h501, 3, 1, 0, 0, 1);
      step("pop4", 32'h401, 2, 1, 0, 0, 1);
      step("pop3", 32'h301, 1, 1, 0, 0, 1);
      step("pop2", 32'h201, 0, 1, 0, 0, 1);
      r1_data = 32'h55;
      step("pop_unf", 32'h55, 0, 1, 1, 0, 1);

      clr(); rst_ = 0; jal = 1; addr = 26'h700;
      step("rst_mid", 32'h0, 0, 0, 0, 0, 1);

      clr(); jmp = 1; jreg = 1; ret = 1; r1_data = 32'h40;
      addr = 26'h77;
      step("multi", 32'h40, 0, 0, 1, 1, 1);
      do_jmp("jmp80", 26'h80, 32'h80, 0, 0, 1);
      clr(); jreg = 1; r1_data = 32'h90;
      step("jreg90", 32'h90, 0, 0, 1, 0, 1);

      clr(); jreg = 1; r1_data = 32'hFFFF_FFFF;
      step("jreg_max", 32'hFFFF_FFFF, 0, 0, 1, 0, 1);
      do_jmp("jmp_hi", 26'h5, 32'hF000_0005, 0, 0, 1);
      clr(); jreg = 1; r1_data = 32'hFFFF_FFFF;
      step("jreg_max2", 32'hFFFF_FFFF, 0, 0, 1, 0, 1);
      clr();
      step("wrap", 32'h0, 0, 0, 1, 0, 0);

      @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
